instr_mem_sync: RTL and testbench

//   Parametrised, clocked instruction memory for the pipelined processor.

---
 rtl/instr_mem_sync.sv | 103 ++++++++++
 tb/tb_instr_mem_sync.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/instr_mem_sync.sv
// Clocked instruction memory: byte-addressed fetch over valid/ready with a fixed
// programmable read latency, runtime program-load port and misalign/range error flag.
module instr_mem_sync #(
  parameter int                DATA_W    = 32,
  parameter int                ADDR_W    = 64,
  parameter int                DEPTH     = 64,
  parameter int                RD_LAT    = 2,
  parameter logic [DATA_W-1:0] FILL      = 32'hD503201F,
  parameter string             INIT_FILE = ""
) (
  input  logic                     CLK,
  input  logic                     resetl,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [ADDR_W-1:0]        req_addr,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [DATA_W-1:0]        rsp_data,
  output logic                     rsp_err,
  input  logic                     ld_en,
  input  logic [$clog2(DEPTH)-1:0] ld_idx,
  input  logic [DATA_W-1:0]        ld_data,
  output logic [1:0]               dbg_state
);

  // Handshake: a transfer happens on a rising edge where valid && ready are both
  // high; request side accepts only in IDLE without a load, response side holds
  // rsp_valid/rsp_data/rsp_err stable in RESP until rsp_ready is sampled high.

  localparam int                IDX_W    = $clog2(DEPTH);
  localparam int                CNT_W    = $clog2(RD_LAT + 1);
  localparam logic [CNT_W-1:0]  LAT_INIT = CNT_W'(RD_LAT - 1);
  localparam logic [ADDR_W-1:0] LIMIT    = ADDR_W'(4 * DEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             accept;
  logic             req_err;
  logic [IDX_W-1:0] req_idx;

  logic [DATA_W-1:0] mem [DEPTH];

  // Array is deliberately outside the reset domain so loaded programs survive reset.
  always_ff @(posedge CLK) begin
    if (ld_en) mem[ld_idx] <= ld_data;
  end

  assign req_ready = (state == IDLE) && !ld_en;
  assign accept    = req_valid && req_ready;
  assign req_idx   = req_addr[IDX_W+1:2];
  assign req_err   = (req_addr[1:0] != 2'b00) || (req_addr >= LIMIT);
  assign rsp_valid = (state == RESP);
  assign dbg_state = state;

  always_ff @(posedge CLK or negedge resetl) begin
    if (!resetl) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    case (state)
      IDLE: begin
        if (accept) begin
          cnt_n   = LAT_INIT;
          state_n = (RD_LAT == 1) ? RESP : WAIT;
        end
      end
      WAIT: begin
        cnt_n = cnt - CNT_W'(1);
        if (cnt == CNT_W'(1)) state_n = RESP;
      end
      RESP: begin
        if (rsp_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Snapshot taken at accept: later loads to the same index cannot disturb it.
  always_ff @(posedge CLK or negedge resetl) begin
    if (!resetl) begin
      rsp_data <= '0;
      rsp_err  <= 1'b0;
    end else if (accept) begin
      rsp_err  <= req_err;
      rsp_data <= req_err ? FILL : mem[req_idx];
    end
  end

endmodule

// File: tb/tb_instr_mem_sync.sv
// Directed bench for instr_mem_sync (DEPTH=64, RD_LAT=2): inputs driven and outputs
// checked on the falling edge, expected values hand-computed.
module tb_instr_mem_sync;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 64;
  localparam int DEPTH  = 64;
  localparam int RD_LAT = 2;

  logic              CLK = 1'b0;
  logic              resetl;
  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_data;
  logic              rsp_err;
  logic              ld_en;
  logic [5:0]        ld_idx;
  logic [DATA_W-1:0] ld_data;
  logic [1:0]        dbg_state;

  int checks = 0;
  int errors = 0;

  instr_mem_sync #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .RD_LAT(RD_LAT)
  ) dut (
    .CLK(CLK), .resetl(resetl),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .ld_en(ld_en), .ld_idx(ld_idx), .ld_data(ld_data),
    .dbg_state(dbg_state)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(negedge CLK);
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic load(input logic [5:0] idx, input logic [31:0] data);
    ld_en = 1'b1; ld_idx = idx; ld_data = data;
    tick();
    ld_en = 1'b0;
  endtask

  // Issue one fetch, wait (bounded) for the response, check it, then consume it.
  task automatic read_word(input string tag, input logic [63:0] addr,
                           input logic [31:0] exp_d, input logic exp_e);
    int lat;
    req_valid = 1'b1; req_addr = addr;
    #1 chk({tag, "_req_ready"}, req_ready, 1);
    tick();
    req_valid = 1'b0;
    chk({tag, "_ready_fall"}, req_ready, 0);
    lat = 1;
    while (!rsp_valid && lat < 10) begin
      tick();
      lat++;
    end
    chk({tag, "_latency"}, lat, RD_LAT);
    chk({tag, "_data"}, rsp_data, exp_d);
    chk({tag, "_err"}, rsp_err, exp_e);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk({tag, "_valid_drop"}, rsp_valid, 0);
  endtask

  initial begin
    resetl = 1'b0; req_valid = 1'b0; req_addr = '0; rsp_ready = 1'b0;
    ld_en = 1'b0; ld_idx = '0; ld_data = '0;
    tick(); tick();
    chk("rst_valid", rsp_valid, 0);
    chk("rst_err", rsp_err, 0);
    chk("rst_data", rsp_data, 0);
    chk("rst_state", dbg_state, 0);
    resetl = 1'b1;
    tick();

    // 1: basic load then fetch
    ld_en = 1'b1; ld_idx = 6'd0; ld_data = 32'hF84003E9;
    #1 chk("ld_blocks_ready", req_ready, 0);
    tick();
    ld_en = 1'b0;
    read_word("t1", 64'h0, 32'hF84003E9, 1'b0);

    // 2: backpressure in RESP
    req_valid = 1'b1; req_addr = 64'h0;
    tick(); req_valid = 1'b0;
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", rsp_valid, 1);
      chk("bp_data", rsp_data, 32'hF84003E9);
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("bp_release_valid", rsp_valid, 0);
    chk("bp_release_ready", req_ready, 1);

    // 3: misaligned, out-of-range (would alias idx0), last valid word
    read_word("misalign", 64'h6, 32'hD503201F, 1'b1);
    read_word("range100", 64'h100, 32'hD503201F, 1'b1);
    read_word("range_hi", 64'h8000_0000_0000_0000, 32'hD503201F, 1'b1);
    load(6'd63, 32'h12345678);
    read_word("last_word", 64'hFC, 32'h12345678, 1'b0);

    // 4: load during WAIT must not change the pending response
    load(6'd7, 32'h8B0901AD);
    req_valid = 1'b1; req_addr = 64'h1C;
    tick(); req_valid = 1'b0;
    chk("snap_in_wait", dbg_state, 1);
    ld_en = 1'b1; ld_idx = 6'd7; ld_data = 32'hCB09018C;
    tick(); ld_en = 1'b0;
    chk("snap_valid", rsp_valid, 1);
    chk("snap_data", rsp_data, 32'h8B0901AD);
    rsp_ready = 1'b1;
    tick(); rsp_ready = 1'b0;
    read_word("reread", 64'h1C, 32'hCB09018C, 1'b0);

    // 5: load wins over a simultaneous request
    ld_en = 1'b1; ld_idx = 6'd2; ld_data = 32'h00000222;
    req_valid = 1'b1; req_addr = 64'h8;
    #1 chk("coll_ready", req_ready, 0);
    tick();
    ld_en = 1'b0;
    chk("coll_no_accept", dbg_state, 0);
    req_valid = 1'b0;
    read_word("coll_next", 64'h8, 32'h00000222, 1'b0);

    // 6: reset during WAIT drops the response, keeps memory
    req_valid = 1'b1; req_addr = 64'h0;
    tick(); req_valid = 1'b0;
    chk("rstw_state", dbg_state, 1);
    resetl = 1'b0;
    #1 chk("rstw_valid_now", rsp_valid, 0);
    tick(); tick();
    chk("rstw_valid_held", rsp_valid, 0);
    resetl = 1'b1;
    tick(); tick();
    chk("rstw_valid_after", rsp_valid, 0);
    chk("rstw_ready_after", req_ready, 1);
    read_word("keep7", 64'h1C, 32'hCB09018C, 1'b0);
    read_word("keep0", 64'h0, 32'hF84003E9, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
